prf_wr_bank_arbiter: RTL and testbench



---
 rtl/prf_wr_bank_arbiter.sv | 134 +++++++++++++
 tb/tb_prf_wr_bank_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prf_wr_bank_arbiter.sv
// Write-side scheduler for the banked physical register file.
// Buffers writes from each requester in a small FIFO, then arbitrates the FIFO
// heads round-robin per bank, issuing at most one registered write per bank per cycle.
module prf_wr_bank_arbiter #(
  parameter int unsigned PRF_WR_COUNT             = 8,
  parameter int unsigned PRF_BANK_COUNT           = 4,
  parameter int unsigned PR_COUNT                 = 128,
  parameter int unsigned XLEN                     = 64,
  parameter int unsigned PRF_WR_INPUT_BUFFER_SIZE = 2,
  localparam int unsigned PR_W   = $clog2(PR_COUNT),
  localparam int unsigned BANK_W = $clog2(PRF_BANK_COUNT),
  localparam int unsigned UPR_W  = PR_W - BANK_W,
  localparam int unsigned SRC_W  = $clog2(PRF_WR_COUNT)
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [PRF_WR_COUNT-1:0]                    valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][PR_W-1:0]          PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]          data_by_wr,
  output logic [PRF_WR_COUNT-1:0]                    ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                  WB_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][UPR_W-1:0]       WB_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]        WB_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]       WB_src_by_bank
);

  localparam int unsigned BUF   = PRF_WR_INPUT_BUFFER_SIZE;
  localparam int unsigned CNT_W = $clog2(BUF + 1);
  localparam int unsigned IDX_W = (BUF > 1) ? $clog2(BUF) : 1;

  // Per-requester FIFO storage; slot 0 is always the head.
  logic [PRF_WR_COUNT-1:0][BUF-1:0][PR_W-1:0] r_pr;
  logic [PRF_WR_COUNT-1:0][BUF-1:0][XLEN-1:0] r_data;
  logic [PRF_WR_COUNT-1:0][CNT_W-1:0]         r_count;
  logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]       r_ptr;

  logic [PRF_WR_COUNT-1:0]                    w_push;
  logic [PRF_WR_COUNT-1:0]                    w_pop;
  logic [PRF_WR_COUNT-1:0][IDX_W-1:0]         w_wr_idx;
  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_req;
  logic [PRF_BANK_COUNT-1:0]                  w_gnt_valid;
  logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]       w_gnt_idx;

  // Ready depends only on occupancy, never on a same-cycle pop.
  always_comb begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      ready_by_wr[i] = (r_count[i] != CNT_W'(BUF));
      w_push[i]      = valid_by_wr[i] & ready_by_wr[i];
    end
  end

  // Each non-empty head requests exactly the bank named by its PR low bits.
  always_comb begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        w_req[b][i] = (r_count[i] != '0) && (r_pr[i][0][BANK_W-1:0] == BANK_W'(b));
      end
    end
  end

  // Per-bank round-robin: first requester at or after the pointer wins.
  always_comb begin
    logic [SRC_W-1:0] cand;
    cand        = '0;
    w_gnt_valid = '0;
    w_gnt_idx   = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        cand = r_ptr[b] + SRC_W'(k);
        if (!w_gnt_valid[b] && w_req[b][cand]) begin
          w_gnt_valid[b] = 1'b1;
          w_gnt_idx[b]   = cand;
        end
      end
    end
  end

  // A head can win at most one bank, so pops are a simple OR of grants.
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (w_gnt_valid[b]) w_pop[w_gnt_idx[b]] = 1'b1;
    end
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      // New entry lands just past the surviving entries after this cycle's pop.
      w_wr_idx[i] = IDX_W'(r_count[i] - CNT_W'(w_pop[i]));
    end
  end

  // FIFO state: shift down on pop, then write the new entry behind survivors.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pr    <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (w_pop[i]) begin
          for (int k = 0; k < BUF - 1; k++) begin
            r_pr[i][k]   <= r_pr[i][k+1];
            r_data[i][k] <= r_data[i][k+1];
          end
        end
        if (w_push[i]) begin
          r_pr[i][w_wr_idx[i]]   <= PR_by_wr[i];
          r_data[i][w_wr_idx[i]] <= data_by_wr[i];
        end
        r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
    end
  end

  // Bank pointers advance past the winner; payload registers hold when idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr               <= '0;
      WB_valid_by_bank    <= '0;
      WB_upper_PR_by_bank <= '0;
      WB_data_by_bank     <= '0;
      WB_src_by_bank      <= '0;
    end else begin
      WB_valid_by_bank <= w_gnt_valid;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_gnt_valid[b]) begin
          r_ptr[b]               <= w_gnt_idx[b] + SRC_W'(1);
          WB_upper_PR_by_bank[b] <= r_pr[w_gnt_idx[b]][0][PR_W-1:BANK_W];
          WB_data_by_bank[b]     <= r_data[w_gnt_idx[b]][0];
          WB_src_by_bank[b]      <= w_gnt_idx[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wr_bank_arbiter.sv
// Directed bench for prf_wr_bank_arbiter: latency, round-robin order,
// parallel banks, backpressure, push/pop at count 1 and mid-traffic reset.
module tb_prf_wr_bank_arbiter;

  logic                  CLK;
  logic                  RST;
  logic [7:0]            valid_by_wr;
  logic [7:0][6:0]       PR_by_wr;
  logic [7:0][63:0]      data_by_wr;
  logic [7:0]            ready_by_wr;
  logic [3:0]            WB_valid_by_bank;
  logic [3:0][4:0]       WB_upper_PR_by_bank;
  logic [3:0][63:0]      WB_data_by_bank;
  logic [3:0][2:0]       WB_src_by_bank;

  int checks = 0;
  int errors = 0;

  prf_wr_bank_arbiter dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .valid_by_wr         (valid_by_wr),
    .PR_by_wr            (PR_by_wr),
    .data_by_wr          (data_by_wr),
    .ready_by_wr         (ready_by_wr),
    .WB_valid_by_bank    (WB_valid_by_bank),
    .WB_upper_PR_by_bank (WB_upper_PR_by_bank),
    .WB_data_by_bank     (WB_data_by_bank),
    .WB_src_by_bank      (WB_src_by_bank)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag, input int b, input logic [4:0] upr,
                          input logic [63:0] d, input logic [2:0] src);
    chk({tag, "_upr"}, 64'(WB_upper_PR_by_bank[b]), 64'(upr));
    chk({tag, "_data"}, WB_data_by_bank[b], d);
    chk({tag, "_src"}, 64'(WB_src_by_bank[b]), 64'(src));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input int i, input logic [6:0] p, input logic [63:0] d);
    valid_by_wr[i] = 1'b1;
    PR_by_wr[i]    = p;
    data_by_wr[i]  = d;
  endtask

  initial begin
    RST         = 1'b1;
    valid_by_wr = '0;
    PR_by_wr    = '0;
    data_by_wr  = '0;
    #3;
    chk("reset_ready", 64'(ready_by_wr), 64'hFF);
    chk("reset_valid", 64'(WB_valid_by_bank), 64'h0);
    chk_bank("reset_b0", 0, 5'h0, 64'h0, 3'd0);
    #9 RST = 1'b0;
    tick();

    // Single write: wr2, PR 0x0D -> bank 1, upper 3.
    put(2, 7'h0D, 64'hDEAD);
    tick();
    valid_by_wr = '0;
    chk("single_e0_valid", 64'(WB_valid_by_bank), 64'h0);
    chk("single_e0_ready", 64'(ready_by_wr), 64'hFF);
    tick();
    chk("single_valid", 64'(WB_valid_by_bank), 64'h2);
    chk_bank("single", 1, 5'h03, 64'hDEAD, 3'd2);
    tick();
    chk("single_pulse_end", 64'(WB_valid_by_bank), 64'h0);

    // Round-robin on bank 0 from ptr 0: order 0,3,5.
    put(0, 7'h10, 64'hA0);
    put(3, 7'h20, 64'hA3);
    put(5, 7'h30, 64'hA5);
    tick();
    valid_by_wr = '0;
    chk("rr_e0_valid", 64'(WB_valid_by_bank), 64'h0);
    tick();
    chk("rr1_valid", 64'(WB_valid_by_bank), 64'h1);
    chk_bank("rr1", 0, 5'h04, 64'hA0, 3'd0);
    tick();
    chk("rr2_valid", 64'(WB_valid_by_bank), 64'h1);
    chk_bank("rr2", 0, 5'h08, 64'hA3, 3'd3);
    tick();
    chk("rr3_valid", 64'(WB_valid_by_bank), 64'h1);
    chk_bank("rr3", 0, 5'h0C, 64'hA5, 3'd5);
    // ptr[0] is now 6: wrap reaches wr0 before wr5.
    put(0, 7'h04, 64'hD0);
    put(5, 7'h08, 64'hD5);
    tick();
    valid_by_wr = '0;
    chk("rr_wrap_e0_valid", 64'(WB_valid_by_bank), 64'h0);
    tick();
    chk_bank("rr_wrap1", 0, 5'h01, 64'hD0, 3'd0);
    tick();
    chk_bank("rr_wrap2", 0, 5'h02, 64'hD5, 3'd5);

    // Parallel banks: wr0..wr3 to banks 0..3 in one cycle.
    put(0, 7'd4, 64'hE0);
    put(1, 7'd9, 64'hE1);
    put(2, 7'd14, 64'hE2);
    put(3, 7'd19, 64'hE3);
    tick();
    valid_by_wr = '0;
    chk("par_e0_valid", 64'(WB_valid_by_bank), 64'h0);
    tick();
    chk("par_valid", 64'(WB_valid_by_bank), 64'hF);
    chk_bank("par_b0", 0, 5'h01, 64'hE0, 3'd0);
    chk_bank("par_b1", 1, 5'h02, 64'hE1, 3'd1);
    chk_bank("par_b2", 2, 5'h03, 64'hE2, 3'd2);
    chk_bank("par_b3", 3, 5'h04, 64'hE3, 3'd3);

    // Backpressure on bank 2 (ptr[2]=3): wr0 streams, wr1 fills to 2.
    put(0, 7'h02, 64'hB0);
    put(1, 7'h06, 64'h1);
    tick();
    chk("bp_a_valid", 64'(WB_valid_by_bank), 64'h0);
    chk("bp_a_ready", 64'(ready_by_wr), 64'hFF);
    put(0, 7'h0A, 64'hB1);
    put(1, 7'h0E, 64'h2);
    tick();
    chk("bp_b_valid", 64'(WB_valid_by_bank), 64'h4);
    chk_bank("bp_b", 2, 5'h00, 64'hB0, 3'd0);
    chk("bp_b_ready", 64'(ready_by_wr), 64'hFD);
    valid_by_wr[1] = 1'b0;
    put(0, 7'h12, 64'hB2);
    tick();
    chk_bank("bp_c", 2, 5'h01, 64'h1, 3'd1);
    chk("bp_c_ready", 64'(ready_by_wr), 64'hFE);
    valid_by_wr = '0;
    tick();
    chk_bank("bp_d", 2, 5'h02, 64'hB1, 3'd0);
    chk("bp_d_ready", 64'(ready_by_wr), 64'hFF);
    tick();
    chk_bank("bp_e", 2, 5'h03, 64'h2, 3'd1);
    tick();
    chk_bank("bp_f", 2, 5'h04, 64'hB2, 3'd0);
    tick();
    chk("bp_idle_valid", 64'(WB_valid_by_bank), 64'h0);

    // Push and pop together at count 1 on wr6 (bank 3).
    put(6, 7'h07, 64'hF1);
    tick();
    chk("pp_e0_ready", 64'(ready_by_wr), 64'hFF);
    chk("pp_e0_valid", 64'(WB_valid_by_bank), 64'h0);
    put(6, 7'h0B, 64'hF2);
    tick();
    valid_by_wr = '0;
    chk("pp1_valid", 64'(WB_valid_by_bank), 64'h8);
    chk_bank("pp1", 3, 5'h01, 64'hF1, 3'd6);
    chk("pp1_ready", 64'(ready_by_wr), 64'hFF);
    tick();
    chk("pp2_valid", 64'(WB_valid_by_bank), 64'h8);
    chk_bank("pp2", 3, 5'h02, 64'hF2, 3'd6);
    tick();
    chk("pp_no_dup", 64'(WB_valid_by_bank), 64'h0);

    // Mid-traffic reset with three entries buffered on bank 1.
    put(4, 7'h01, 64'h41);
    put(5, 7'h05, 64'h51);
    put(7, 7'h09, 64'h71);
    tick();
    valid_by_wr = '0;
    RST = 1'b1;
    #1;
    chk("mrst_valid", 64'(WB_valid_by_bank), 64'h0);
    chk("mrst_ready", 64'(ready_by_wr), 64'hFF);
    for (int b = 0; b < 4; b++) chk_bank($sformatf("mrst_b%0d", b), b, 5'h0, 64'h0, 3'd0);
    #2 RST = 1'b0;
    tick();
    chk("mrst_drain1", 64'(WB_valid_by_bank), 64'h0);
    tick();
    chk("mrst_drain2", 64'(WB_valid_by_bank), 64'h0);
    // ptr[1] back at 0: wr1 beats wr4.
    put(1, 7'h01, 64'hC1);
    put(4, 7'h05, 64'hC4);
    tick();
    valid_by_wr = '0;
    chk("mrst_e0_valid", 64'(WB_valid_by_bank), 64'h0);
    tick();
    chk("mrst_g1_valid", 64'(WB_valid_by_bank), 64'h2);
    chk_bank("mrst_g1", 1, 5'h00, 64'hC1, 3'd1);
    tick();
    chk_bank("mrst_g2", 1, 5'h01, 64'hC4, 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
